// File: rtl/hls_infer_pkg.sv
// Shared types and defaults for the HLS inference core initiator (hls_infer_driver).
package hls_infer_pkg;

    typedef enum logic [1:0] {FILL, LAUNCH, WAIT, HOLD} state_t;

    localparam int N_SAMPLES_DEF   = 75;
    localparam int SAMPLE_W_DEF    = 24;
    localparam int OUT_W_DEF       = 24;
    localparam int TIMEOUT_CYC_DEF = 4096;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = cnt_width(N_SAMPLES_DEF);

endpackage

// File: rtl/hls_infer_driver.sv
// Initiator for the ap_ctrl_hs inference core: packs a sample frame, launches the core, captures both scores.
// Optional watchdog on the core's ap_done is enabled by defining HLS_TIMEOUT_EN.
module hls_infer_driver
    import hls_infer_pkg::*;
#(
    parameter int N_SAMPLES   = N_SAMPLES_DEF,
    parameter int SAMPLE_W    = SAMPLE_W_DEF,
    parameter int OUT_W       = OUT_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SAMPLE_W-1:0]             s_data,
    input  logic                            s_valid,
    input  logic                            s_last,
    output logic                            s_ready,
    output logic                            hls_start,
    output logic [N_SAMPLES*SAMPLE_W-1:0]   hls_input,
    output logic                            hls_input_vld,
    input  logic                            hls_done,
    input  logic [OUT_W-1:0]                hls_out_0,
    input  logic [OUT_W-1:0]                hls_out_1,
    input  logic                            hls_out_0_vld,
    input  logic                            hls_out_1_vld,
    output logic [OUT_W-1:0]                r_score_0,
    output logic [OUT_W-1:0]                r_score_1,
    output logic                            r_valid,
    input  logic                            r_ready,
    output logic                            busy,
    output logic                            frame_err,
    output logic                            timeout_err
);

    localparam int CW = cnt_width(N_SAMPLES);
    localparam int IW = cnt_width(N_SAMPLES * SAMPLE_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(N_SAMPLES - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [IW-1:0] wr_lsb;
    logic          s_hs;
    logic          at_last;
    logic          wd_fire;

    assign s_hs    = s_valid && s_ready;
    assign at_last = (cnt == CNT_LAST);
    assign wr_lsb  = IW'(cnt) * IW'(SAMPLE_W);
    assign busy    = (state != FILL) || (cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL:    if (s_hs && at_last)      state_nxt = LAUNCH;
            LAUNCH:                            state_nxt = WAIT;
            WAIT:    if (hls_done || wd_fire)  state_nxt = HOLD;
            HOLD:    if (r_ready)              state_nxt = FILL;
            default:                           state_nxt = FILL;
        endcase
    end

    always_comb begin
        s_ready       = 1'b0;
        hls_start     = 1'b0;
        hls_input_vld = 1'b0;
        r_valid       = 1'b0;
        unique case (state)
            FILL:    s_ready = 1'b1;
            LAUNCH:  begin hls_start = 1'b1; hls_input_vld = 1'b1; end
            WAIT:    ;
            HOLD:    r_valid = 1'b1;
            default: ;
        endcase
    end

    // Packer: a frame that ends early is dropped but its samples stay in the vector until overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            hls_input <= '0;
            frame_err <= 1'b0;
        end else if (s_hs) begin
            hls_input[wr_lsb +: SAMPLE_W] <= s_data;
            if (at_last) begin
                cnt <= '0;
                if (!s_last) frame_err <= 1'b1;
            end else if (s_last) begin
                cnt       <= '0;
                frame_err <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // A score that never strobes reads back as 0 because its register is cleared at launch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_score_0 <= '0;
            r_score_1 <= '0;
        end else if (state == LAUNCH) begin
            r_score_0 <= '0;
            r_score_1 <= '0;
        end else if (state == WAIT) begin
            if (hls_out_0_vld) r_score_0 <= hls_out_0;
            if (hls_out_1_vld) r_score_1 <= hls_out_1;
        end
    end

`ifdef HLS_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    assign wd_fire     = (state == WAIT) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    assign timeout_err = timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == LAUNCH)
                wd_cnt <= '0;
            else if (state == WAIT && !wd_fire)
                wd_cnt <= wd_cnt + 1'b1;
            if (wd_fire && !hls_done)
                timeout_q <= 1'b1;
        end
    end
`else
    assign wd_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_hls_infer_driver.sv
// Randomized bench for hls_infer_driver with a frame/score reference model; watchdog expectations follow HLS_TIMEOUT_EN.
module tb_hls_infer_driver;

    localparam int N  = 75;
    localparam int W  = 24;
    localparam int OW = 24;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [W-1:0]      s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_last = 1'b0;
    logic              s_ready;
    logic              hls_start;
    logic [N*W-1:0]    hls_input;
    logic              hls_input_vld;
    logic              hls_done = 1'b0;
    logic [OW-1:0]     hls_out_0 = '0;
    logic [OW-1:0]     hls_out_1 = '0;
    logic              hls_out_0_vld = 1'b0;
    logic              hls_out_1_vld = 1'b0;
    logic [OW-1:0]     r_score_0;
    logic [OW-1:0]     r_score_1;
    logic              r_valid;
    logic              r_ready = 1'b0;
    logic              busy;
    logic              frame_err;
    logic              timeout_err;

    int                n_checks = 0;
    int                n_pass   = 0;
    logic [W-1:0]      exp_vec [N];
    logic [OW-1:0]     exp0, exp1;
    logic              exp_ferr;

    hls_infer_driver #(
        .N_SAMPLES(N), .SAMPLE_W(W), .OUT_W(OW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .hls_start(hls_start), .hls_input(hls_input), .hls_input_vld(hls_input_vld),
        .hls_done(hls_done), .hls_out_0(hls_out_0), .hls_out_1(hls_out_1),
        .hls_out_0_vld(hls_out_0_vld), .hls_out_1_vld(hls_out_1_vld),
        .r_score_0(r_score_0), .r_score_1(r_score_1), .r_valid(r_valid), .r_ready(r_ready),
        .busy(busy), .frame_err(frame_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected bench completion");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_s_ready"}, 64'(s_ready), 64'd1);
        chk({tag, "_start"},   64'(hls_start), 64'd0);
        chk({tag, "_in_vld"},  64'(hls_input_vld), 64'd0);
        chk({tag, "_r_valid"}, 64'(r_valid), 64'd0);
        chk({tag, "_busy"},    64'(busy), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check_idle(tag);
        chk({tag, "_score0"},  64'(r_score_0), 64'd0);
        chk({tag, "_score1"},  64'(r_score_1), 64'd0);
        chk({tag, "_ferr"},    64'(frame_err), 64'd0);
        chk({tag, "_terr"},    64'(timeout_err), 64'd0);
        chk({tag, "_vec_nz"},  64'(|hls_input), 64'd0);
    endtask

    task automatic check_vec(input string tag);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s_vec%0d", tag, i), 64'(hls_input[i*W +: W]), 64'(exp_vec[i]));
    endtask

    // Streams n samples with random idle gaps; s_last on index last_pos (-1 = never).
    task automatic send_frame(input int n, input int last_pos, input bit rnd);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            s_data  = rnd ? W'($urandom) : W'(i + 1);
            s_valid = 1'b1;
            s_last  = (i == last_pos);
            exp_vec[i] = s_data;
            if (i == last_pos && i < N - 1) exp_ferr = 1'b1;
            if (i == N - 1 && i != last_pos) exp_ferr = 1'b1;
            tick();
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    // Called one cycle after the last handshake: expects LAUNCH, then steps into WAIT.
    task automatic launch_check(input string tag);
        chk({tag, "_start"},   64'(hls_start), 64'd1);
        chk({tag, "_in_vld"},  64'(hls_input_vld), 64'd1);
        chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        chk({tag, "_ferr"},    64'(frame_err), 64'(exp_ferr));
        check_vec(tag);
        tick();
        chk({tag, "_start_off"},  64'(hls_start), 64'd0);
        chk({tag, "_in_vld_off"}, 64'(hls_input_vld), 64'd0);
        exp0 = '0;
        exp1 = '0;
    endtask

    // Core model: cycle j (1 = first WAIT cycle) may strobe scores; done on cycle d. 0 = no strobe.
    task automatic run_core(input string tag, input int d, input int p0, input logic [OW-1:0] v0,
                            input int p1, input logic [OW-1:0] v1, input int p0b);
        for (int j = 1; j <= d; j++) begin
            hls_out_0     = OW'($urandom);
            hls_out_1     = OW'($urandom);
            hls_out_0_vld = (j == p0) || (j == p0b);
            hls_out_1_vld = (j == p1);
            if (j == p0) hls_out_0 = v0;
            if (j == p1) hls_out_1 = v1;
            if (hls_out_0_vld) exp0 = hls_out_0;
            if (hls_out_1_vld) exp1 = hls_out_1;
            hls_done = (j == d);
            tick();
            if (j < d) chk({tag, "_no_rvalid"}, 64'(r_valid), 64'd0);
        end
        hls_out_0_vld = 1'b0;
        hls_out_1_vld = 1'b0;
        hls_done      = 1'b0;
        chk({tag, "_r_valid"}, 64'(r_valid), 64'd1);
        chk({tag, "_score0"},  64'(r_score_0), 64'(exp0));
        chk({tag, "_score1"},  64'(r_score_1), 64'(exp1));
        chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    endtask

    task automatic consume(input string tag, input int hold);
        r_ready = 1'b0;
        repeat (hold) tick();
        chk({tag, "_held"},       64'(r_valid), 64'd1);
        chk({tag, "_held_s0"},    64'(r_score_0), 64'(exp0));
        chk({tag, "_held_s1"},    64'(r_score_1), 64'(exp1));
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        check_idle({tag, "_done"});
    endtask

    initial begin
        exp_ferr = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check_reset_state("reset");

        // hls_done outside WAIT has no effect
        hls_done = 1'b1;
        tick();
        hls_done = 1'b0;
        tick();
        check_idle("stray_done");

        // Directed frame: samples 1..75, scores at +5/+6, done at +6
        send_frame(N, N - 1, 1'b0);
        chk("dir_lsb", 64'(hls_input[23:0]), 64'd1);
        chk("dir_msb", 64'(hls_input[1799:1776]), 64'd75);
        launch_check("dir");
        run_core("dir", 6, 5, 24'h00A000, 6, 24'hFF6000, 0);
        chk("dir_s0_val", 64'(r_score_0), 64'h00A000);
        chk("dir_s1_val", 64'(r_score_1), 64'hFF6000);
        check_vec("dir_hold");
        consume("dir", 10);

        // Random frames; the first delivers only score 0
        for (int f = 0; f < 4; f++) begin
            int d, p0, p1, p0b;
            d   = $urandom_range(1, 12);
            p0  = $urandom_range(1, d);
            p1  = (f == 0) ? 0 : (($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, d));
            p0b = (f == 0) ? 0 : $urandom_range(0, d);
            send_frame(N, N - 1, 1'b1);
            launch_check($sformatf("rnd%0d", f));
            run_core($sformatf("rnd%0d", f), d, p0, OW'($urandom), p1, OW'($urandom), p0b);
            consume($sformatf("rnd%0d", f), $urandom_range(0, 4));
        end

        // Early s_last: frame dropped, no launch; next full frame launches
        send_frame(41, 40, 1'b1);
        chk("early_ferr",  64'(frame_err), 64'd1);
        chk("early_start", 64'(hls_start), 64'd0);
        repeat (3) tick();
        check_idle("early_idle");
        send_frame(N, N - 1, 1'b1);
        launch_check("after_early");
        run_core("after_early", 3, 1, OW'($urandom), 2, OW'($urandom), 0);
        consume("after_early", 1);

        // Reset clears sticky error; missing s_last still launches but flags
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ferr = 1'b0;
        tick();
        check_reset_state("rst2");
        send_frame(N, -1, 1'b1);
        launch_check("no_last");
        run_core("no_last", 2, 2, OW'($urandom), 1, OW'($urandom), 0);
        consume("no_last", 0);

        // Reset mid-WAIT
        send_frame(N, N - 1, 1'b1);
        launch_check("mid");
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("mid_async_rvalid", 64'(r_valid), 64'd0);
        chk("mid_async_vec",    64'(|hls_input), 64'd0);
        tick();
        rst = 1'b0;
        exp_ferr = 1'b0;
        tick();
        check_reset_state("mid_rst");

        // Core never signals done
        send_frame(N, N - 1, 1'b1);
        launch_check("to");
        begin
            logic [OW-1:0] tv;
            tv = OW'($urandom);
            for (int j = 1; j <= TO; j++) begin
                hls_out_0_vld = (j == 3);
                hls_out_0     = (j == 3) ? tv : OW'($urandom);
                tick();
                if (j == 3) exp0 = tv;
                if (j == TO - 1) chk("to_not_yet", 64'(r_valid), 64'd0);
            end
            hls_out_0_vld = 1'b0;
        end
`ifdef HLS_TIMEOUT_EN
        chk("to_rvalid", 64'(r_valid), 64'd1);
        chk("to_err",    64'(timeout_err), 64'd1);
        chk("to_score0", 64'(r_score_0), 64'(exp0));
        chk("to_score1", 64'(r_score_1), 64'd0);
        hls_done = 1'b1;
        tick();
        hls_done = 1'b0;
        consume("to_late", 2);
        chk("to_err_sticky", 64'(timeout_err), 64'd1);
`else
        chk("to_off_rvalid", 64'(r_valid), 64'd0);
        repeat (30) tick();
        chk("to_off_still", 64'(r_valid), 64'd0);
        chk("to_off_busy",  64'(busy), 64'd1);
        chk("to_off_err",   64'(timeout_err), 64'd0);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check_reset_state("final_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
